// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - 32-bit program counter with jump, PC-relative branch and sequential update
module program_counter_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          INSTR_BYTES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] jump_target,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_out
);

    localparam logic [31:0] STEP       = 32'(INSTR_BYTES);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] pc_q;
    logic [31:0] next_pc;

    // A zero target means "no request", so jump beats branch beats sequential.
    // Two's-complement addition makes negative branch offsets move backward.
    always_comb begin
        next_pc = pc_q + STEP;
        if (jump_target != 32'd0) begin
            next_pc = jump_target & ALIGN_MASK;
        end else if (branch_target != 32'd0) begin
            next_pc = (pc_q + branch_target) & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= next_pc;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// tb/tb_program_counter_unit.sv - scoreboard bench for program_counter_unit
module tb_program_counter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] pc_out;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    event        chk_ev;

    program_counter_unit dut (
        .clk          (clk),
        .reset        (reset),
        .jump_target  (jump_target),
        .branch_target(branch_target),
        .pc_out       (pc_out)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation per observation point, away from posedge.
    always @(negedge clk or chk_ev) begin
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (pc_out !== e) begin
                n_err++;
                $display("FAIL %s: pc_out=%08h expected=%08h", nm, pc_out, e);
            end
        end
    end

    task automatic step(input logic [31:0] jt, input logic [31:0] bt,
                        input logic [31:0] exp, input string nm);
        jump_target   = jt;
        branch_target = bt;
        @(posedge clk);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, pending=%0d expected=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        jump_target   = 32'h0040_0008;
        branch_target = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            exp_q.push_back(32'h0);
            name_q.push_back("reset_hold");
            #1;
        end
        @(negedge clk);
        #1;
        reset         = 1'b0;
        step(32'h0, 32'h0, 32'h0000_0004, "seq_first");
        step(32'h0, 32'h0, 32'h0000_0008, "seq_second");

        step(32'h0040_0008, 32'h0, 32'h0040_0008, "jump");
        step(32'h0040_0008, 32'h0, 32'h0040_0008, "jump_held");
        step(32'h0040_0009, 32'h0, 32'h0040_0008, "jump_align");

        step(32'h0040_0008, 32'h0000_000C, 32'h0040_0008, "prio_jump");
        step(32'h0,         32'h0000_000C, 32'h0040_0014, "branch_fwd");
        step(32'h0,         32'h0000_000C, 32'h0040_0020, "branch_held");

        step(32'h0000_0100, 32'h0,         32'h0000_0100, "jump_100");
        step(32'h0,         32'hFFFF_FFF8, 32'h0000_00F8, "branch_neg");
        step(32'h0,         32'h0,         32'h0000_00FC, "seq_after_neg");
        step(32'h0,         32'h0000_0007, 32'h0000_0100, "branch_align");

        step(32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, "jump_top");
        step(32'h0,         32'h0,         32'h0000_0000, "wrap_seq");
        step(32'h0,         32'h0,         32'h0000_0004, "seq_after_wrap");
        step(32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFF4, "branch_underflow");
        step(32'h0,         32'h0000_0010, 32'h0000_0004, "branch_overflow");
        step(32'h0,         32'h0,         32'h0000_0008, "seq_count");

        // Asynchronous reset pulse strictly between rising edges.
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back(32'h0);
        name_q.push_back("async_reset");
        #1;
        -> chk_ev;
        #1;
        reset = 1'b0;
        step(32'h0, 32'h0, 32'h0000_0004, "resume_first");
        step(32'h0, 32'h0, 32'h0000_0008, "resume_second");

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
